// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ packet streams.
// A grant lasts for a packet, at most MAXBURST words, or until STALL_MAX idle cycles.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned DSIZE     = 80,
  parameter int unsigned MAXBURST  = 16,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0]               req_last,
  input  logic [NREQ*(DSIZE-IDW)-1:0]   req_data,
  output logic [NREQ-1:0]               req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DSIZE-1:0]              wdata,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int unsigned PSIZE  = DSIZE - IDW;
  localparam int unsigned BurstW = $clog2(MAXBURST + 1);
  localparam int unsigned StallW = $clog2(STALL_MAX + 1);

  localparam logic [IDW-1:0]    LastId   = IDW'(NREQ - 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAXBURST);
  localparam logic [StallW-1:0] StallMax = StallW'(STALL_MAX);

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("fifo_wr_arbiter: IDW must equal clog2(NREQ)");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("fifo_wr_arbiter: NREQ must be in 2..16");
  end
  if (MAXBURST < 1 || STALL_MAX < 1) begin : g_bad_limits
    $error("fifo_wr_arbiter: MAXBURST and STALL_MAX must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [StallW-1:0] stall_q, stall_d;

  // View of the currently granted requester.
  logic             sel_valid;
  logic             sel_last;
  logic [PSIZE-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*PSIZE +: PSIZE];
      end
    end
  end

  // Round-robin pick: first valid requester after rr_ptr, wrapping at NREQ.
  logic           any_valid;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;

  always_comb begin
    any_valid = 1'b0;
    winner    = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (cand == LastId) ? '0 : cand + IDW'(1);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  logic              xfer;
  logic [BurstW-1:0] burst_inc;
  logic [StallW-1:0] stall_inc;

  assign xfer      = (state_q == StGrant) && sel_valid && !wfull;
  assign burst_inc = burst_q + BurstW'(1);
  assign stall_inc = (stall_q == StallMax) ? stall_q : stall_q + StallW'(1);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= LastId;
      grant_q  <= '0;
      burst_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    stall_d  = stall_q;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d  = StGrant;
          grant_d  = winner;
          rr_ptr_d = winner;
          burst_d  = '0;
          stall_d  = '0;
        end
      end
      StGrant: begin
        if (xfer) begin
          burst_d = burst_inc;
          stall_d = '0;
          if (sel_last || (burst_inc == BurstMax)) begin
            state_d = StIdle;
          end
        end else if (!sel_valid) begin
          // A full FIFO is not a stall; only missing data counts.
          stall_d = stall_inc;
          if (stall_inc == StallMax) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StGrant);
    winc      = xfer;
    req_ready = '0;
    wdata     = {grant_q, {PSIZE{1'b0}}};
    if (state_q == StGrant) begin
      req_ready[grant_q] = !wfull;
      wdata              = {grant_q, sel_data};
    end
  end

  assign grant_id = grant_q;

  a_ready_onehot0: assert property (@(posedge wclk) disable iff (!wrst_n)
    $onehot0(req_ready));
  a_no_write_full: assert property (@(posedge wclk) disable iff (!wrst_n)
    winc |-> !wfull);
  a_winc_handshake: assert property (@(posedge wclk) disable iff (!wrst_n)
    winc |-> (req_ready[grant_q] && req_valid[grant_q]));
  a_burst_bound: assert property (@(posedge wclk) disable iff (!wrst_n)
    burst_q <= BurstMax);
  a_stall_bound: assert property (@(posedge wclk) disable iff (!wrst_n)
    stall_q <= StallMax);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a packet-level behavioural model of the arbiter.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int DSIZE     = 80;
  localparam int MAXBURST  = 16;
  localparam int STALL_MAX = 8;
  localparam int PSIZE     = DSIZE - IDW;

  logic                    wclk;
  logic                    wrst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_last;
  logic [NREQ*PSIZE-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    wfull;
  logic                    winc;
  logic [DSIZE-1:0]        wdata;
  logic [IDW-1:0]          grant_id;
  logic                    busy;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .DSIZE(DSIZE), .MAXBURST(MAXBURST), .STALL_MAX(STALL_MAX)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_pass = 0;
  int n_total = 0;

  // Packet sources: rem words left, pos words sent, plen packet length (0 = no last).
  int              rem[NREQ];
  int              pos[NREQ];
  int              plen[NREQ];
  logic [NREQ-1:0] mute;
  int              wf_cnt;
  bit              rnd_mode;
  int              rnd_vp;

  // Reference model state.
  bit m_busy;
  int m_owner;
  int m_words;
  int m_stall;
  int m_rr;
  bit m_xfer;

  logic             exp_busy;
  logic             exp_winc;
  logic [NREQ-1:0]  exp_ready;
  logic [DSIZE-1:0] exp_wdata;
  logic [IDW-1:0]   exp_gid;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (rnd_mode) begin
        req_valid[i] = ($urandom_range(0, 99) < rnd_vp);
        req_last[i]  = ($urandom_range(0, 3) == 0);
        req_data[i*PSIZE +: PSIZE] = PSIZE'({$urandom(), $urandom(), $urandom()});
      end else begin
        req_valid[i] = (rem[i] > 0) && !mute[i];
        req_last[i]  = (plen[i] > 0) && ((pos[i] % plen[i]) == plen[i] - 1);
        req_data[i*PSIZE +: PSIZE] = PSIZE'(i * 4096 + pos[i]);
      end
    end
    wfull = rnd_mode ? ($urandom_range(0, 3) == 0) : (wf_cnt > 0);
  endtask

  task automatic model_comb();
    m_xfer    = m_busy && req_valid[m_owner] && !wfull;
    exp_busy  = m_busy;
    exp_winc  = m_xfer;
    exp_gid   = IDW'(m_owner);
    exp_ready = '0;
    if (m_busy && !wfull) exp_ready[m_owner] = 1'b1;
    exp_wdata = {IDW'(m_owner), PSIZE'(0)};
    if (m_busy) exp_wdata[PSIZE-1:0] = req_data[m_owner*PSIZE +: PSIZE];
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (req_valid[(m_rr + k) % NREQ]) begin
          m_owner = (m_rr + k) % NREQ;
          m_rr    = m_owner;
          m_busy  = 1;
          m_words = 0;
          m_stall = 0;
          break;
        end
      end
    end else if (m_xfer) begin
      m_words++;
      m_stall = 0;
      if (req_last[m_owner] || m_words == MAXBURST) m_busy = 0;
    end else if (!req_valid[m_owner]) begin
      m_stall++;
      if (m_stall == STALL_MAX) m_busy = 0;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_words = 0; m_stall = 0; m_rr = NREQ - 1; m_xfer = 0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; pos[i] = 0; plen[i] = 0;
    end
    mute = '0; wf_cnt = 0; rnd_mode = 0;
  endtask

  task automatic tick();
    @(posedge wclk);
    if (!rnd_mode && m_xfer) begin
      rem[m_owner]--;
      pos[m_owner]++;
    end
    if (wf_cnt > 0) wf_cnt--;
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0;
    clear_sources();
    req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    @(posedge wclk);
    @(posedge wclk);
    #1;
    model_reset();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b1;
    req_valid = '1; req_last = '0; req_data = '1; wfull = 1'b0;
    #1 wrst_n = 1'b0;
    #2;
    n_total++;
    if (busy !== 1'b0 || winc !== 1'b0 || req_ready !== '0 || wdata !== '0 || grant_id !== '0)
      $display("FAIL reset_async: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want all zero",
               busy, winc, req_ready, grant_id, wdata);
    else n_pass++;
    @(posedge wclk);
    #2;
    n_total++;
    if (busy !== 1'b0 || winc !== 1'b0 || req_ready !== '0 || wdata !== '0 || grant_id !== '0)
      $display("FAIL reset_held: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want all zero",
               busy, winc, req_ready, grant_id, wdata);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_single_packet();
    logic want;
    rem[2] = 3; plen[2] = 3;
    for (int c = 0; c < 6; c++) begin
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid)
        $display("FAIL single c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                 c, busy, winc, req_ready, grant_id, wdata,
                 exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      else n_pass++;
      want = (c >= 1 && c <= 3);
      n_total++;
      if (winc !== want || busy !== want || (want && wdata[DSIZE-1 -: IDW] !== 2'd2))
        $display("FAIL single_seq c%0d: got winc=%b busy=%b id_field=%0d want winc=%b busy=%b id_field=2",
                 c, winc, busy, wdata[DSIZE-1 -: IDW], want, want);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_rr_order();
    int got[$];
    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
    int g;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin rem[i] = 100; plen[i] = 1; end
    for (int c = 0; c < 14; c++) begin
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid)
        $display("FAIL rr c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                 c, busy, winc, req_ready, grant_id, wdata,
                 exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      else n_pass++;
      n_total++;
      if (winc !== ((c % 2) == 1))
        $display("FAIL rr_bubble c%0d: got winc=%b want %b", c, winc, (c % 2) == 1);
      else n_pass++;
      if (winc === 1'b1) got.push_back(int'(grant_id));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      g = (k < got.size()) ? got[k] : -1;
      n_total++;
      if (g != exp_ord[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, g, exp_ord[k]);
      else n_pass++;
    end
  endtask

  task automatic test_burst_split();
    int run_id[$];
    int run_len[$];
    int ones[$];
    int after1[$];
    int exp_b[3] = '{16, 16, 8};
    int cur_id, cur_len, g;
    logic prev_busy;
    apply_reset();
    rem[1] = 40; plen[1] = 0;
    rem[0] = 1000; plen[0] = 1;
    cur_id = 0; cur_len = 0; prev_busy = 1'b0;
    for (int c = 0; c < 80; c++) begin
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid)
        $display("FAIL burst c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                 c, busy, winc, req_ready, grant_id, wdata,
                 exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      else n_pass++;
      if (winc === 1'b1) begin cur_id = int'(grant_id); cur_len++; end
      if (prev_busy && busy === 1'b0) begin
        run_id.push_back(cur_id); run_len.push_back(cur_len); cur_len = 0;
      end
      prev_busy = busy;
      tick();
    end
    for (int r = 0; r < run_id.size(); r++) begin
      if (run_id[r] == 1) begin
        ones.push_back(run_len[r]);
        after1.push_back((r + 1 < run_id.size()) ? run_id[r+1] : -1);
      end
    end
    n_total++;
    if (ones.size() != 3) $display("FAIL burst_count: got %0d grants want 3", ones.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      g = (k < ones.size()) ? ones[k] : -1;
      n_total++;
      if (g != exp_b[k]) $display("FAIL burst_len[%0d]: got %0d want %0d", k, g, exp_b[k]);
      else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      g = (k < after1.size()) ? after1[k] : -1;
      n_total++;
      if (g != 0) $display("FAIL burst_interleave[%0d]: got id %0d want 0", k, g);
      else n_pass++;
    end
  endtask

  task automatic test_wfull_hold();
    bit wf_done, closed, seen_busy;
    int full_cycles, g_words;
    apply_reset();
    rem[3] = 20; plen[3] = 0;
    wf_done = 0; closed = 0; seen_busy = 0; full_cycles = 0; g_words = 0;
    for (int c = 0; c < 40; c++) begin
      if (!wf_done && m_busy && m_owner == 3 && m_words == 3) begin
        wf_cnt = 5; wf_done = 1;
      end
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid)
        $display("FAIL wfull c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                 c, busy, winc, req_ready, grant_id, wdata,
                 exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      else n_pass++;
      if (wfull) begin
        full_cycles++;
        n_total++;
        if (winc !== 1'b0 || req_ready[3] !== 1'b0 || busy !== 1'b1)
          $display("FAIL wfull_hold c%0d: got winc=%b rdy3=%b busy=%b want 0 0 1",
                   c, winc, req_ready[3], busy);
        else n_pass++;
      end
      if (busy === 1'b1) seen_busy = 1;
      if (seen_busy && busy === 1'b0) closed = 1;
      if (!closed && winc === 1'b1) g_words++;
      tick();
    end
    n_total++;
    if (full_cycles != 5) $display("FAIL wfull_cycles: got %0d want 5", full_cycles);
    else n_pass++;
    n_total++;
    if (g_words != MAXBURST) $display("FAIL wfull_burst: got %0d words want %0d", g_words, MAXBURST);
    else n_pass++;
  endtask

  task automatic test_stall_revoke();
    bit muted_done, released;
    int mute_cnt, stall_busy, next_id;
    apply_reset();
    rem[2] = 10; plen[2] = 0;
    rem[3] = 1000; plen[3] = 1;
    muted_done = 0; released = 0; mute_cnt = 0; stall_busy = 0; next_id = -1;
    for (int c = 0; c < 40; c++) begin
      if (!muted_done && m_busy && m_owner == 2 && m_words == 2) begin
        mute[2] = 1'b1; mute_cnt = 12; muted_done = 1;
      end
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid)
        $display("FAIL stall c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                 c, busy, winc, req_ready, grant_id, wdata,
                 exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      else n_pass++;
      if (mute[2] && busy === 1'b1 && grant_id === 2'd2) stall_busy++;
      if (mute[2] && busy === 1'b0) released = 1;
      if (released && next_id < 0 && winc === 1'b1) next_id = int'(grant_id);
      tick();
      if (mute_cnt > 0) begin
        mute_cnt--;
        if (mute_cnt == 0) mute[2] = 1'b0;
      end
    end
    n_total++;
    if (stall_busy != STALL_MAX)
      $display("FAIL stall_len: got %0d stalled grant cycles want %0d", stall_busy, STALL_MAX);
    else n_pass++;
    n_total++;
    if (next_id != 3) $display("FAIL stall_next: got id %0d want 3", next_id);
    else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    bit found;
    int first_id;
    apply_reset();
    rem[1] = 10; plen[1] = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid)
        $display("FAIL rstmid c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                 c, busy, winc, req_ready, grant_id, wdata,
                 exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      else n_pass++;
      if (m_busy && m_owner == 1 && m_words == 3) found = 1;
      else tick();
    end
    n_total++;
    if (!found || winc !== 1'b1) $display("FAIL rstmid_setup: got found=%0d winc=%b want 1 1", found, winc);
    else n_pass++;
    #1 wrst_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || winc !== 1'b0 || req_ready !== '0)
      $display("FAIL rstmid_async: got busy=%b winc=%b rdy=%b want 0 0 0", busy, winc, req_ready);
    else n_pass++;
    @(posedge wclk);
    #1;
    clear_sources();
    for (int i = 0; i < NREQ; i++) begin rem[i] = 5; plen[i] = 1; end
    model_reset();
    wrst_n = 1'b1;
    first_id = -1;
    for (int c = 0; c < 8; c++) begin
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid)
        $display("FAIL rstmid_after c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                 c, busy, winc, req_ready, grant_id, wdata,
                 exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      else n_pass++;
      if (first_id < 0 && winc === 1'b1) first_id = int'(grant_id);
      tick();
    end
    n_total++;
    if (first_id != 0) $display("FAIL rstmid_priority: got first id %0d want 0", first_id);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    apply_reset();
    rnd_mode = 1;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      rnd_vp = (c < 1500) ? 70 : 15;
      drive_inputs(); #1; model_comb();
      n_total++;
      if (busy !== exp_busy || winc !== exp_winc || req_ready !== exp_ready ||
          wdata !== exp_wdata || grant_id !== exp_gid) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random c%0d: got busy=%b winc=%b rdy=%b id=%0d wdata=%h want busy=%b winc=%b rdy=%b id=%0d wdata=%h",
                   c, busy, winc, req_ready, grant_id, wdata,
                   exp_busy, exp_winc, exp_ready, exp_gid, exp_wdata);
      end else n_pass++;
      tick();
    end
    rnd_mode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    clear_sources();
    model_reset();
    rnd_vp = 50;
    test_reset();
    test_single_packet();
    test_rr_order();
    test_burst_split();
    test_wfull_hold();
    test_stall_revoke();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
